// File: rtl/usb_rx_fifo_unpacker.sv
// ---------------------------------------------------------------------------
// usb_rx_fifo_unpacker
// Read-side consumer of the USB slave RX dual-clock FIFO (AXI clk domain).
// Pops {last, rsvd, halfword[15:0]} entries, packs halfword pairs into
// 32-bit beats and presents them on a valid/ready stream with byte strobes
// and a frame-last flag. Outstanding FIFO reads are credit-limited so the
// FIFO read latency can never overrun the local skid buffer.
//
// Ports
//   clk            AXI-domain clock (also the FIFO rdclk)
//   rst_n          asynchronous active-low reset (also the FIFO aclr)
//   fifo_rdreq_o   FIFO read request, one entry per high cycle
//   fifo_q_i       FIFO read data, valid RD_LATENCY cycles after rdreq
//   fifo_rdempty_i FIFO read-side empty flag (may be pessimistic)
//   out_valid_o    output beat valid
//   out_ready_i    output beat accepted when valid & ready
//   out_data_o     {hw1, hw0}, hw0 is the earlier halfword
//   out_strb_o     4'b1111 full beat, 4'b0011 single-halfword beat
//   out_last_o     beat ends a frame
//   frame_cnt_o    completed frames (accepted beats with last), wraps
//   busy_o         entry in flight, buffered, half-packed or in output reg
// ---------------------------------------------------------------------------
module usb_rx_fifo_unpacker #(
  parameter int unsigned FIFO_WIDTH = 20,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned SKID_DEPTH = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  fifo_rdreq_o,
  input  logic [FIFO_WIDTH-1:0] fifo_q_i,
  input  logic                  fifo_rdempty_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [31:0]           out_data_o,
  output logic [3:0]            out_strb_o,
  output logic                  out_last_o,
  output logic [CNT_WIDTH-1:0]  frame_cnt_o,
  output logic                  busy_o
);

  localparam int unsigned PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(SKID_DEPTH + 1);
  localparam int unsigned OUT_W = $clog2(SKID_DEPTH + RD_LATENCY + 1);

  typedef enum logic {
    ST_LOW,
    ST_HIGH
  } pack_state_t;

  // Read-request enable: released one cycle after reset deasserts so the
  // request stays low during reset regardless of the empty flag.
  logic                  run_q;

  logic [RD_LATENCY-1:0] inflight_q;
  logic [RD_LATENCY-1:0] inflight_nxt;
  logic [OUT_W-1:0]      inflight_cnt;
  logic [OUT_W-1:0]      outstanding;

  logic [FIFO_WIDTH-1:0] skid_mem [SKID_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [OCC_W-1:0]      skid_cnt_q;

  logic                  landing;
  logic                  skid_has_data;
  logic                  head_valid;
  logic [FIFO_WIDTH-1:0] head;
  logic                  head_last;
  logic [15:0]           head_hw;
  logic                  out_free;
  logic                  pop;
  logic                  skid_wr;
  logic                  skid_rd;

  pack_state_t           state_q;
  logic [15:0]           hw0_q;

  logic                  unused_rsvd;

  // ---------------------------------------------------------------- credit
  always_comb begin
    inflight_cnt = '0;
    for (int unsigned i = 0; i < RD_LATENCY; i++) begin
      inflight_cnt = inflight_cnt + OUT_W'(inflight_q[i]);
    end
    // The landing entry is still counted in inflight_q; a pop this cycle only
    // lowers skid_cnt_q next cycle, so credit release is one cycle late.
    outstanding  = inflight_cnt + OUT_W'(skid_cnt_q);
    fifo_rdreq_o = run_q && !fifo_rdempty_i && (outstanding < OUT_W'(SKID_DEPTH));
  end

  always_comb begin
    inflight_nxt    = inflight_q << 1;
    inflight_nxt[0] = fifo_rdreq_o;
  end

  // ------------------------------------------------------------- skid head
  // When the skid is empty the landing entry is the head and is consumed
  // straight from fifo_q_i; this keeps the buffer at zero occupancy in
  // steady state so one pop per cycle fits within SKID_DEPTH credits.
  assign landing       = inflight_q[RD_LATENCY-1];
  assign skid_has_data = (skid_cnt_q != '0);
  assign head_valid    = skid_has_data || landing;
  assign head          = skid_has_data ? skid_mem[rd_ptr_q] : fifo_q_i;
  assign head_last     = head[FIFO_WIDTH-1];
  assign head_hw       = head[15:0];
  assign unused_rsvd   = ^head[FIFO_WIDTH-2:16];

  assign out_free = !out_valid_o || out_ready_i;
  assign pop      = head_valid && out_free;
  assign skid_wr  = landing && !(pop && !skid_has_data);
  assign skid_rd  = pop && skid_has_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= 1'b0;
      inflight_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      skid_cnt_q <= '0;
    end else begin
      run_q      <= 1'b1;
      inflight_q <= inflight_nxt;
      if (skid_wr) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (skid_rd) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({skid_wr, skid_rd})
        2'b10:   skid_cnt_q <= skid_cnt_q + OCC_W'(1);
        2'b01:   skid_cnt_q <= skid_cnt_q - OCC_W'(1);
        default: skid_cnt_q <= skid_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (skid_wr) skid_mem[wr_ptr_q] <= fifo_q_i;
  end

  // ----------------------------------------------- packer + output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOW;
      hw0_q       <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_strb_o  <= '0;
      out_last_o  <= 1'b0;
      frame_cnt_o <= '0;
    end else begin
      if (out_valid_o && out_ready_i) begin
        out_valid_o <= 1'b0;
        if (out_last_o) frame_cnt_o <= frame_cnt_o + CNT_WIDTH'(1);
      end
      if (pop) begin
        case (state_q)
          ST_LOW: begin
            if (head_last) begin
              out_valid_o <= 1'b1;
              out_data_o  <= {16'h0000, head_hw};
              out_strb_o  <= 4'b0011;
              out_last_o  <= 1'b1;
            end else begin
              hw0_q   <= head_hw;
              state_q <= ST_HIGH;
            end
          end
          ST_HIGH: begin
            out_valid_o <= 1'b1;
            out_data_o  <= {head_hw, hw0_q};
            out_strb_o  <= 4'b1111;
            out_last_o  <= head_last;
            state_q     <= ST_LOW;
          end
          default: state_q <= ST_LOW;
        endcase
      end
    end
  end

  assign busy_o = (|inflight_q) || skid_has_data || (state_q == ST_HIGH) || out_valid_o;

  // Credit accounting guarantees the skid never overflows.
  skid_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(skid_wr && !skid_rd && (skid_cnt_q == OCC_W'(SKID_DEPTH))));

endmodule
